// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: per-source edge/level capture, maskable, one request at a time.
// irq rises 2 cycles after a source rises; held until irq_ack, then at least 2 cycles low before the next request.
module irq_ctrl #(
    parameter int                N_SRC      = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0000_0100),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h0000_0010),
    parameter logic [N_SRC-1:0]  EDGE_MASK  = {N_SRC{1'b1}},
    parameter logic [N_SRC-1:0]  MASK_RST   = {N_SRC{1'b0}},
    localparam int               ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_wd,
    output logic [N_SRC-1:0]  mask,
    output logic [N_SRC-1:0]  pending,
    output logic              irq,
    input  logic              irq_ack,
    output logic [ADDR_W-1:0] irq_addr,
    output logic [ID_W-1:0]   irq_id,
    output logic [15:0]       svc_count
);

    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    src_q;
    logic [N_SRC-1:0]    pend_q, pend_d;
    logic [N_SRC-1:0]    mask_q, mask_d;
    logic                irq_q, irq_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         svc_q, svc_d;

    logic [N_SRC-1:0]    set_vec;
    logic [N_SRC-1:0]    clr_vec;
    logic [N_SRC-1:0]    pend_eff;
    logic [N_SRC-1:0]    req;
    logic                win_vld;
    logic [ID_W-1:0]     win_id;

    always_comb begin
        set_vec  = src & ~src_q & EDGE_MASK;
        pend_eff = (pend_q & EDGE_MASK) | (src_q & ~EDGE_MASK);
        req      = pend_eff & mask_q;

        // Scan high to low so the lowest active index is the last one written.
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end

        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        svc_d   = svc_q;
        clr_vec = '0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ASSERT;
                    id_d    = win_id;
                    addr_d  = VEC_BASE + VEC_STRIDE * ADDR_W'(win_id);
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    clr_vec = N_SRC'(1) << id_q;
                    svc_d   = svc_q + 16'd1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh edge in the ack cycle must survive the clear.
        pend_d = (pend_q & ~clr_vec) | set_vec;
        mask_d = mask_we ? mask_wd : mask_q;
        irq_d  = (state_d == ASSERT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            pend_q  <= '0;
            mask_q  <= MASK_RST;
            irq_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= VEC_BASE;
            svc_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            svc_q   <= svc_d;
        end
    end

    assign mask      = mask_q;
    assign pending   = pend_eff;
    assign irq       = irq_q;
    assign irq_id    = id_q;
    assign irq_addr  = addr_q;
    assign svc_count = svc_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: source 0 level-sensitive, sources 1..3 edge-sensitive, mask resets to 0.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic [3:0]  mask;
    logic [3:0]  pending;
    logic        irq;
    logic        irq_ack;
    logic [31:0] irq_addr;
    logic [1:0]  irq_id;
    logic [15:0] svc_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_SRC     (4),
        .ADDR_W    (32),
        .VEC_BASE  (32'h0000_0100),
        .VEC_STRIDE(32'h0000_0010),
        .EDGE_MASK (4'b1110),
        .MASK_RST  (4'b0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .mask_we  (mask_we),
        .mask_wd  (mask_wd),
        .mask     (mask),
        .pending  (pending),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .irq_addr (irq_addr),
        .irq_id   (irq_id),
        .svc_count(svc_count)
    );

    typedef struct {
        logic [3:0]  src;
        logic        mwe;
        logic [3:0]  mwd;
        logic        ack;
        logic        e_irq;
        logic [1:0]  e_id;
        logic [31:0] e_addr;
        logic [3:0]  e_pend;
        logic [3:0]  e_mask;
        logic [15:0] e_svc;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic [1:0] id, input logic [31:0] addr);
        chk({tag, " irq"}, 32'(irq), 32'd1);
        chk({tag, " id"}, 32'(irq_id), 32'(id));
        chk({tag, " addr"}, irq_addr, addr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " irq"}, 32'(irq), 32'd0);
        chk({tag, " id"}, 32'(irq_id), 32'd0);
        chk({tag, " addr"}, irq_addr, 32'h100);
        chk({tag, " mask"}, 32'(mask), 32'h0);
        chk({tag, " pending"}, 32'(pending), 32'h0);
        chk({tag, " svc"}, 32'(svc_count), 32'd0);
    endtask

    initial begin
        //          src  we wd   ack  irq id  addr     pend mask svc
        tbl[0]  = '{4'h0, 1, 4'hF, 0, 0, 0, 32'h100, 4'h0, 4'hF, 16'd0};
        tbl[1]  = '{4'h4, 0, 4'h0, 0, 0, 0, 32'h100, 4'h4, 4'hF, 16'd0};
        tbl[2]  = '{4'h0, 0, 4'h0, 0, 1, 2, 32'h120, 4'h4, 4'hF, 16'd0};
        tbl[3]  = '{4'h0, 0, 4'h0, 0, 1, 2, 32'h120, 4'h4, 4'hF, 16'd0};
        tbl[4]  = '{4'h0, 0, 4'h0, 1, 0, 0, 32'h0,   4'h0, 4'hF, 16'd1};
        tbl[5]  = '{4'h0, 0, 4'h0, 0, 0, 0, 32'h0,   4'h0, 4'hF, 16'd1};
        tbl[6]  = '{4'hA, 0, 4'h0, 0, 0, 0, 32'h0,   4'hA, 4'hF, 16'd1};
        tbl[7]  = '{4'h0, 0, 4'h0, 0, 1, 1, 32'h110, 4'hA, 4'hF, 16'd1};
        tbl[8]  = '{4'h0, 0, 4'h0, 1, 0, 0, 32'h0,   4'h8, 4'hF, 16'd2};
        tbl[9]  = '{4'h0, 0, 4'h0, 0, 0, 0, 32'h0,   4'h8, 4'hF, 16'd2};
        tbl[10] = '{4'h0, 0, 4'h0, 0, 1, 3, 32'h130, 4'h8, 4'hF, 16'd2};
        tbl[11] = '{4'h0, 0, 4'h0, 1, 0, 0, 32'h0,   4'h0, 4'hF, 16'd3};
        tbl[12] = '{4'h0, 0, 4'h0, 0, 0, 0, 32'h0,   4'h0, 4'hF, 16'd3};
        tbl[13] = '{4'h0, 1, 4'h0, 0, 0, 0, 32'h0,   4'h0, 4'h0, 16'd3};
        tbl[14] = '{4'h2, 0, 4'h0, 0, 0, 0, 32'h0,   4'h2, 4'h0, 16'd3};
        tbl[15] = '{4'h0, 0, 4'h0, 0, 0, 0, 32'h0,   4'h2, 4'h0, 16'd3};
        tbl[16] = '{4'h0, 0, 4'h0, 0, 0, 0, 32'h0,   4'h2, 4'h0, 16'd3};
        tbl[17] = '{4'h0, 1, 4'h2, 0, 0, 0, 32'h0,   4'h2, 4'h2, 16'd3};
        tbl[18] = '{4'h0, 0, 4'h0, 0, 1, 1, 32'h110, 4'h2, 4'h2, 16'd3};
        tbl[19] = '{4'h0, 1, 4'h0, 0, 1, 1, 32'h110, 4'h2, 4'h0, 16'd3};
        tbl[20] = '{4'h0, 0, 4'h0, 0, 1, 1, 32'h110, 4'h2, 4'h0, 16'd3};
        tbl[21] = '{4'h0, 0, 4'h0, 1, 0, 0, 32'h0,   4'h0, 4'h0, 16'd4};
        tbl[22] = '{4'h0, 0, 4'h0, 0, 0, 0, 32'h0,   4'h0, 4'h0, 16'd4};
        tbl[23] = '{4'h0, 0, 4'h0, 1, 0, 0, 32'h0,   4'h0, 4'h0, 16'd4};
        tbl[24] = '{4'h0, 1, 4'hF, 0, 0, 0, 32'h0,   4'h0, 4'hF, 16'd4};

        rst = 1'b0; src = '0; mask_we = 1'b0; mask_wd = '0; irq_ack = 1'b0;
        #12;
        chk_reset("reset");
        tick();
        rst = 1'b1;

        foreach (tbl[i]) begin
            src = tbl[i].src; mask_we = tbl[i].mwe; mask_wd = tbl[i].mwd; irq_ack = tbl[i].ack;
            tick();
            chk($sformatf("row%0d irq", i), 32'(irq), 32'(tbl[i].e_irq));
            chk($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
            chk($sformatf("row%0d mask", i), 32'(mask), 32'(tbl[i].e_mask));
            chk($sformatf("row%0d svc", i), 32'(svc_count), 32'(tbl[i].e_svc));
            if (tbl[i].e_irq) begin
                chk($sformatf("row%0d id", i), 32'(irq_id), 32'(tbl[i].e_id));
                chk($sformatf("row%0d addr", i), irq_addr, tbl[i].e_addr);
            end
        end
        mask_we = 1'b0; irq_ack = 1'b0;

        // Edge on the serviced source in its own ack cycle
        src = 4'h4; tick();
        src = 4'h0; tick(); chk_req("sameack first", 2, 32'h120);
        src = 4'h4; irq_ack = 1'b1; tick();
        chk("sameack irq", 32'(irq), 32'd0);
        chk("sameack pending", 32'(pending), 32'h4);
        chk("sameack svc", 32'(svc_count), 32'd5);
        src = 4'h0; irq_ack = 1'b0; tick();
        chk("sameack gap", 32'(irq), 32'd0);
        tick(); chk_req("sameack again", 2, 32'h120);
        irq_ack = 1'b1; tick();
        chk("sameack2 svc", 32'(svc_count), 32'd6);
        chk("sameack2 pending", 32'(pending), 32'h0);
        irq_ack = 1'b0; tick();

        // Level source 0 held high: re-presented after each ack with a 2-cycle gap
        src = 4'h1; tick();
        chk("level pending", 32'(pending), 32'h1);
        chk("level not yet", 32'(irq), 32'd0);
        tick(); chk_req("level req1", 0, 32'h100);
        for (int k = 0; k < 2; k++) begin
            irq_ack = 1'b1; tick();
            chk($sformatf("level ack%0d irq", k), 32'(irq), 32'd0);
            chk($sformatf("level ack%0d svc", k), 32'(svc_count), 32'(7 + k));
            irq_ack = 1'b0; tick();
            chk($sformatf("level gap%0d irq", k), 32'(irq), 32'd0);
            tick(); chk_req($sformatf("level rereq%0d", k), 0, 32'h100);
        end
        src = 4'h0; tick();
        chk("level hold irq", 32'(irq), 32'd1);
        irq_ack = 1'b1; tick();
        chk("level final svc", 32'(svc_count), 32'd9);
        irq_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("level quiet%0d", k), 32'(irq), 32'd0);
        end

        // Reset during ASSERT, then src held high across release
        src = 4'h8; tick();
        src = 4'h0; tick(); chk_req("prerst", 3, 32'h130);
        #2 rst = 1'b0;
        #1 chk_reset("midrst");
        src = 4'h9;
        tick(); tick();
        chk("inrst irq", 32'(irq), 32'd0);
        rst = 1'b1; mask_we = 1'b1; mask_wd = 4'hF;
        tick();
        chk("rel irq", 32'(irq), 32'd0);
        chk("rel pending", 32'(pending), 32'h9);
        chk("rel mask", 32'(mask), 32'hF);
        mask_we = 1'b0; tick(); chk_req("rel req", 0, 32'h100);
        src = 4'h8; irq_ack = 1'b1; tick();
        chk("rel ack svc", 32'(svc_count), 32'd1);
        chk("rel ack pending", 32'(pending), 32'h8);
        irq_ack = 1'b0; tick();
        chk("rel gap", 32'(irq), 32'd0);
        tick(); chk_req("rel edge3", 3, 32'h130);
        irq_ack = 1'b1; tick();
        chk("rel ack2 svc", 32'(svc_count), 32'd2);
        chk("rel ack2 irq", 32'(irq), 32'd0);
        irq_ack = 1'b0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
